// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the program counter, issues word reads on the
// instruction bus, hands fetched words to decode and stalls the core while no
// word is available. Redirects from execute replace the sequential increment.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        i_exec_stall,
  input  logic        i_mem_stall,
  output logic        o_fetch_stall,
  input  logic        i_jump_valid,
  input  logic [31:0] i_jump_addr,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  output logic [31:0] o_IAddr,
  output logic        o_IRd,
  input  logic [31:0] i_IData,
  input  logic        i_IRdy
);

  localparam logic [31:0] NOP = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_START = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;

  logic        fetch_stall;
  logic        advance;
  logic        jump_take;
  logic [31:0] jump_tgt;
  logic [31:0] pc_inc;

  assign jump_tgt  = i_jump_addr & ~32'h3;
  assign pc_inc    = pc_q + 32'd4;
  assign advance   = !i_exec_stall && !i_mem_stall && !fetch_stall;
  assign jump_take = i_jump_valid && advance;

  // The bus address and the reported pc are always the current program counter;
  // a read is requested only while waiting for a word.
  assign o_IAddr       = pc_q;
  assign o_pc          = pc_q;
  assign o_IRd         = (state_q == S_FETCH);
  assign o_fetch_stall = fetch_stall;

  // Fetch stalls during the post-reset bubble and while the bus has not answered.
  always_comb begin
    fetch_stall = 1'b1;
    case (state_q)
      S_START: fetch_stall = 1'b1;
      S_FETCH: fetch_stall = !i_IRdy;
      S_HOLD:  fetch_stall = 1'b0;
      default: fetch_stall = 1'b1;
    endcase
  end

  // Word handed to decode; a redirect in the same cycle squashes it to a NOP.
  always_comb begin
    o_instr = NOP;
    case (state_q)
      S_FETCH: if (i_IRdy && !jump_take) o_instr = i_IData;
      S_HOLD:  if (!jump_take) o_instr = buf_q;
      default: o_instr = NOP;
    endcase
  end

  // Next pc, hold buffer and state: advance or redirect when the core moves,
  // park the returned word in the buffer when the core is stalled.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    case (state_q)
      S_START: state_d = S_FETCH;
      S_FETCH: begin
        if (i_IRdy) begin
          if (jump_take) begin
            pc_d = jump_tgt;
          end else if (advance) begin
            pc_d = pc_inc;
          end else begin
            buf_d   = i_IData;
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (advance) begin
          pc_d    = jump_take ? jump_tgt : pc_inc;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_START;
    endcase
  end

  // State registers; reset drops the read request immediately and restarts at RESET_PC.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= S_START;
      pc_q    <= RESET_PC;
      buf_q   <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      buf_q   <= buf_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized bench for instr_fetch: drives random bus readiness, stalls and
// redirects, and compares every output each cycle against a word-level model.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk;
  logic        nrst;
  logic        i_exec_stall;
  logic        i_mem_stall;
  logic        o_fetch_stall;
  logic        i_jump_valid;
  logic [31:0] i_jump_addr;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic [31:0] o_IAddr;
  logic        o_IRd;
  logic [31:0] i_IData;
  logic        i_IRdy;

  int checkCount = 0;
  int passCount  = 0;

  // Reference model: a post-reset bubble flag, a parked word (if any) and the pc.
  logic        mdlBubble;
  logic        mdlHolding;
  logic [31:0] mdlHeld;
  logic [31:0] mdlPc;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk          (clk),
    .nrst         (nrst),
    .i_exec_stall (i_exec_stall),
    .i_mem_stall  (i_mem_stall),
    .o_fetch_stall(o_fetch_stall),
    .i_jump_valid (i_jump_valid),
    .i_jump_addr  (i_jump_addr),
    .o_instr      (o_instr),
    .o_pc         (o_pc),
    .o_IAddr      (o_IAddr),
    .o_IRd        (o_IRd),
    .i_IData      (i_IData),
    .i_IRdy       (i_IRdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Contents of instruction memory at a given word address.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got === exp) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
  endtask

  // Randomize this cycle's inputs; bus data is the memory word at the model pc.
  task automatic applyStimulus();
    i_IRdy       = ($urandom_range(0, 9) < 6);
    i_exec_stall = ($urandom_range(0, 9) < 2);
    i_mem_stall  = ($urandom_range(0, 9) < 2);
    i_jump_valid = ($urandom_range(0, 9) < 2);
    if ($urandom_range(0, 3) == 0) i_jump_addr = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
    else                           i_jump_addr = $urandom;
    i_IData = memWord(mdlPc);
  endtask

  // Compare all outputs against the model for the current inputs, then advance the model.
  task automatic modelCycle();
    logic        wordReady;
    logic [31:0] word;
    logic        expRd, expStall, move, jump;
    logic [31:0] expInstr;
    wordReady = 1'b0;
    word      = 32'h0;
    expRd     = 1'b0;
    if (mdlBubble) begin
      wordReady = 1'b0;
    end else if (mdlHolding) begin
      wordReady = 1'b1;
      word      = mdlHeld;
    end else begin
      expRd = 1'b1;
      if (i_IRdy) begin
        wordReady = 1'b1;
        word      = memWord(mdlPc);
      end
    end
    expStall = !wordReady;
    move     = wordReady && !i_exec_stall && !i_mem_stall;
    jump     = i_jump_valid && move;
    expInstr = (wordReady && !jump) ? word : 32'h0;

    checkOutput("IRd",        {31'b0, o_IRd},         {31'b0, expRd});
    checkOutput("IAddr",      o_IAddr,                mdlPc);
    checkOutput("pc",         o_pc,                   mdlPc);
    checkOutput("fetchStall", {31'b0, o_fetch_stall}, {31'b0, expStall});
    checkOutput("instr",      o_instr,                expInstr);

    if (mdlBubble) begin
      mdlBubble = 1'b0;
    end else if (wordReady) begin
      if (move) begin
        mdlPc      = jump ? {i_jump_addr[31:2], 2'b00} : mdlPc + 32'd4;
        mdlHolding = 1'b0;
      end else begin
        mdlHolding = 1'b1;
        mdlHeld    = word;
      end
    end
  endtask

  task automatic modelReset();
    mdlBubble  = 1'b1;
    mdlHolding = 1'b0;
    mdlHeld    = 32'h0;
    mdlPc      = RESET_PC;
  endtask

  initial begin
    nrst         = 1'b0;
    i_exec_stall = 1'b0;
    i_mem_stall  = 1'b0;
    i_jump_valid = 1'b0;
    i_jump_addr  = 32'h0;
    i_IData      = 32'h0;
    i_IRdy       = 1'b1;
    modelReset();

    repeat (3) @(negedge clk);
    checkOutput("rstIRd",   {31'b0, o_IRd},         32'h0);
    checkOutput("rstStall", {31'b0, o_fetch_stall}, 32'h1);
    checkOutput("rstInstr", o_instr,                32'h0);
    checkOutput("rstPc",    o_pc,                   RESET_PC);
    checkOutput("rstIAddr", o_IAddr,                RESET_PC);
    nrst = 1'b1;

    for (int cyc = 0; cyc < 4000; cyc++) begin
      applyStimulus();
      #1;
      modelCycle();
      if (cyc % 397 == 396 && o_IRd) begin
        // Reset in the middle of a cycle: the read request must drop at once.
        #1 nrst = 1'b0;
        #1;
        checkOutput("midRstIRd",   {31'b0, o_IRd},         32'h0);
        checkOutput("midRstStall", {31'b0, o_fetch_stall}, 32'h1);
        checkOutput("midRstIAddr", o_IAddr,                RESET_PC);
        modelReset();
        @(posedge clk);
        @(negedge clk);
        nrst = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
